// File: rtl/md_pkg.sv
// md_pkg: shared op/state encodings for the multiply/divide sequencer
package md_pkg;
  localparam int MD_ITER = 32;
  localparam logic [1:0] MD_MULT = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV = 2'b10;
  localparam logic [1:0] MD_DIVU = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
endpackage

// File: rtl/ex_md_step.sv
// ex_md_step: one shift-add multiply or restoring-divide iteration
module ex_md_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc,
  input  logic [WIDTH-1:0] opnd,
  input  logic             div,
  output logic [2*WIDTH:0] nxt
);
  logic [WIDTH:0] sum;
  logic [WIDTH+1:0] sh;
  logic [WIDTH:0] diff;
  logic ge;
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    sh = {acc[2*WIDTH:WIDTH], acc[WIDTH-1]};
    ge = sh >= {2'b0, opnd};
    diff = sh[WIDTH:0] - {1'b0, opnd};
    nxt = div ? {ge ? diff : sh[WIDTH:0], acc[WIDTH-2:0], ge} : {1'b0, sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
module ex_muldiv_ctrl import md_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int ITER = MD_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EX_md_start,
  input  logic [1:0]       EX_md_op,
  input  logic [WIDTH-1:0] EX_rd1,
  input  logic [WIDTH-1:0] EX_alu_in2,
  input  logic             EX_hi_we,
  input  logic             EX_lo_we,
  output logic             EX_md_busy,
  output logic             EX_md_done,
  output logic [WIDTH-1:0] EX_md_hi,
  output logic [WIDTH-1:0] EX_md_lo
);
  localparam int CW = $clog2(ITER + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH:0] acc_q, acc_d, acc_nxt;
  logic [WIDTH-1:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d, ma, mb, quo, rem;
  logic [2*WIDTH-1:0] prod;
  logic div_q, div_d, nres_q, nres_d, nrem_q, nrem_d, busy_q, busy_d, done_q, done_d;
  logic sgn, sa, sb;
  ex_md_step #(.WIDTH(WIDTH)) u_step (.acc(acc_q), .opnd(opnd_q), .div(div_q), .nxt(acc_nxt));
  always_comb begin
    sgn = EX_md_op inside {MD_MULT, MD_DIV};
    sa = sgn & EX_rd1[WIDTH-1];
    sb = sgn & EX_alu_in2[WIDTH-1];
    ma = sa ? -EX_rd1 : EX_rd1;
    mb = sb ? -EX_alu_in2 : EX_alu_in2;
    prod = nres_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    quo = nres_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem = nrem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    opnd_d = opnd_q;
    div_d = div_q;
    nres_d = nres_q;
    nrem_d = nrem_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    unique case (state_q)
      S_IDLE:
        if (EX_md_start) begin
          div_d = EX_md_op inside {MD_DIV, MD_DIVU};
          acc_d = {{(WIDTH+1){1'b0}}, div_d ? ma : mb};
          opnd_d = div_d ? mb : ma;
          nres_d = sa ^ sb;
          nrem_d = sa;
          cnt_d = CW'(ITER);
          state_d = S_CALC;
        end else begin
          hi_d = EX_hi_we ? EX_rd1 : hi_q;
          lo_d = EX_lo_we ? EX_rd1 : lo_q;
        end
      S_CALC:
        if (cnt_q != '0) begin
          acc_d = acc_nxt;
          cnt_d = cnt_q - CW'(1);
        end else state_d = S_FIX;
      S_FIX: begin
        hi_d = div_q ? rem : prod[2*WIDTH-1:WIDTH];
        lo_d = div_q ? quo : prod[WIDTH-1:0];
        done_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      opnd_q <= '0;
      div_q <= 1'b0;
      nres_q <= 1'b0;
      nrem_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opnd_q <= opnd_d;
      div_q <= div_d;
      nres_q <= nres_d;
      nrem_q <= nrem_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign EX_md_busy = busy_q;
  assign EX_md_done = done_q;
  assign EX_md_hi = hi_q;
  assign EX_md_lo = lo_q;
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl: directed scoreboard bench for the multiply/divide sequencer
module tb_ex_muldiv_ctrl;
  import md_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic hi_we = 1'b0;
  logic lo_we = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] rd1 = '0;
  logic [31:0] in2 = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int d0;
  logic [31:0] last_hi = '0;
  logic [31:0] prev_hi;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int at;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  ex_muldiv_ctrl dut (
    .clk(clk), .reset(reset), .EX_md_start(start), .EX_md_op(op),
    .EX_rd1(rd1), .EX_alu_in2(in2), .EX_hi_we(hi_we), .EX_lo_we(lo_we),
    .EX_md_busy(busy), .EX_md_done(done), .EX_md_hi(hi), .EX_md_lo(lo)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    logic [63:0] p;
    x = longint'($signed(a));
    y = longint'($signed(b));
    case (o)
      MD_MULT: p = 64'(x * y);
      MD_MULTU: p = {32'b0, a} * {32'b0, b};
      MD_DIV: p = (b == 0) ? {a, a[31] ? 32'd1 : 32'hFFFFFFFF} : {32'(x % y), 32'(x / y)};
      default: p = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
    endcase
    return p;
  endfunction
  always @(negedge clk) if (done) begin
    done_cnt++;
    chk("busy_in_done", {63'b0, busy}, 64'd0);
    if (sb.size() == 0) chk("unexpected_done", 64'(sb.size()), 64'd1);
    else begin
      e = sb.pop_front();
      chk("hi", {32'b0, hi}, {32'b0, e.hi});
      chk("lo", {32'b0, lo}, {32'b0, e.lo});
      chk("latency", 64'(cyc), 64'(e.at));
    end
  end
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic lw);
    logic [63:0] m;
    m = model(o, a, b);
    last_hi = m[63:32];
    op = o;
    rd1 = a;
    in2 = b;
    lo_we = lw;
    start = 1'b1;
    sb.push_back('{m[63:32], m[31:0], cyc + 1 + 34});
    @(negedge clk);
    start = 1'b0;
    lo_we = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_timeout", 64'(sb.size()), 64'd0);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    launch(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    for (int k = 0; k < 34; k++) begin
      chk("busy_window", {63'b0, busy}, 64'd1);
      @(negedge clk);
    end
    #1;
    chk("busy_after", {63'b0, busy}, 64'd0);
    chk("done_pulse", {63'b0, done}, 64'd1);
    chk("multu_hi", {32'b0, hi}, 64'hFFFFFFFE);
    chk("multu_lo", {32'b0, lo}, 64'h00000001);
    launch(MD_MULT, 32'hFFFFFFFD, 32'd5, 1'b0);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mult_done_seen", {63'b0, done}, 64'd1);
    launch(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_done();
    launch(MD_DIVU, 32'h12345678, 32'd0, 1'b0);
    wait_done();
    launch(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_done();
    launch(MD_DIV, 32'hFFFFFFFB, 32'd0, 1'b0);
    wait_done();
    prev_hi = last_hi;
    d0 = done_cnt;
    launch(MD_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    op = MD_MULTU;
    rd1 = 32'd2;
    in2 = 32'd2;
    start = 1'b1;
    hi_we = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    #1;
    chk("busy_hi_we_ignored", {32'b0, hi}, {32'b0, prev_hi});
    wait_done();
    repeat (40) @(negedge clk);
    chk("single_done", 64'(done_cnt - d0), 64'd1);
    chk("divu_hi", {32'b0, hi}, 64'd2);
    chk("divu_lo", {32'b0, lo}, 64'd14);
    rd1 = 32'hA5A5A5A5;
    hi_we = 1'b1;
    @(negedge clk);
    hi_we = 1'b0;
    #1;
    chk("mthi", {32'b0, hi}, 64'hA5A5A5A5);
    chk("mthi_no_done", {63'b0, done}, 64'd0);
    rd1 = 32'h5A5A5A5A;
    lo_we = 1'b1;
    @(negedge clk);
    lo_we = 1'b0;
    #1;
    chk("mtlo", {32'b0, lo}, 64'h5A5A5A5A);
    chk("mtlo_hi_kept", {32'b0, hi}, 64'hA5A5A5A5);
    launch(MD_MULTU, 32'd3, 32'd4, 1'b1);
    chk("start_lo_we_dropped", {32'b0, lo}, 64'h5A5A5A5A);
    wait_done();
    chk("start_lo_we_result", {32'b0, lo}, 64'd12);
    launch(MD_MULT, 32'h00001234, 32'hFFFFFFFE, 1'b0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_hi", {32'b0, hi}, 64'd0);
    chk("abort_lo", {32'b0, lo}, 64'd0);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    launch(MD_MULTU, 32'd7, 32'd6, 1'b0);
    wait_done();
    chk("post_abort_lo", {32'b0, lo}, 64'd42);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
